// File: rtl/window_addr_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// window_addr_pkg: states and geometry helpers for window_addr_gen. Rev 1.0
// ------------------------------------------------------------------------
package window_addr_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Padded dimension; serves for both width (PW) and height (PH).
  function automatic int pad_dim(input int img, input int kernel);
    return img + kernel - 1;
  endfunction

  // Output dimension; serves for both OUT_W and OUT_H.
  function automatic int out_dim(input int img, input int stride);
    return (img - 1) / stride + 1;
  endfunction

  function automatic bit depth_ok(input int img_w, input int img_h,
                                  input int kernel, input int addr_w);
    longint depth;
    longint cap;
    depth = longint'(pad_dim(img_w, kernel)) * longint'(pad_dim(img_h, kernel));
    cap   = longint'(1) << addr_w;
    return depth <= cap;
  endfunction

  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_addr_gen_wrap_counter.sv
`default_nettype none
// ------------------------------------------------------------------------
// wrap_counter: modulo counter with enable, clear and terminal flag. Rev 1.0
// ------------------------------------------------------------------------
module wrap_counter #(
  parameter int MODULUS = 2,
  parameter int WIDTH   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == c_MAX);

endmodule
`default_nettype wire

// File: rtl/window_addr_gen.sv
`default_nettype none
// ------------------------------------------------------------------------
// window_addr_gen: KERNEL x KERNEL window tap address sequencer. Rev 1.0
// ------------------------------------------------------------------------
module window_addr_gen
  import window_addr_pkg::*;
#(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int KERNEL = 5,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              win_first,
  output logic              win_last,
  output logic [15:0]       out_x,
  output logic [15:0]       out_y,
  output logic              busy,
  output logic              done
);

  localparam int c_PW    = pad_dim(IMG_W, KERNEL);
  localparam int c_OUT_W = out_dim(IMG_W, STRIDE);
  localparam int c_OUT_H = out_dim(IMG_H, STRIDE);
  localparam int c_K_CW  = cnt_width(KERNEL);
  localparam int c_OX_CW = cnt_width(c_OUT_W);
  localparam int c_OY_CW = cnt_width(c_OUT_H);

  localparam logic [ADDR_W-1:0] c_ROW_STEP  = ADDR_W'(c_PW);
  localparam logic [ADDR_W-1:0] c_COL_STEP  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] c_LINE_STEP = ADDR_W'(STRIDE * c_PW);

  generate
    if (!depth_ok(IMG_W, IMG_H, KERNEL, ADDR_W) || (KERNEL % 2 == 0) || (STRIDE < 1)) begin : g_param_check
      $error("window_addr_gen: illegal KERNEL/STRIDE or padded image exceeds ADDR_W");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] win_q, win_d;
  logic [ADDR_W-1:0] line_q, line_d;

  logic [c_K_CW-1:0]  w_kx, w_ky;
  logic [c_OX_CW-1:0] w_ox;
  logic [c_OY_CW-1:0] w_oy;
  logic w_kx_wrap, w_ky_wrap, w_ox_wrap, w_oy_wrap;
  logic w_valid, w_hs, w_cnt_clr, w_final;

  assign w_valid   = (state_q == ST_RUN);
  assign w_hs      = w_valid & addr_ready;
  assign w_cnt_clr = abort | ~w_valid;
  assign w_final   = w_kx_wrap & w_ky_wrap & w_ox_wrap & w_oy_wrap;

  // Chained via wrap flags: kx fastest, then ky, out_x, out_y.
  wrap_counter #(.MODULUS(KERNEL), .WIDTH(c_K_CW)) u_kx (
    .clk(clk), .rst(rst), .clr_i(w_cnt_clr), .en_i(w_hs),
    .cnt_o(w_kx), .wrap_o(w_kx_wrap)
  );
  wrap_counter #(.MODULUS(KERNEL), .WIDTH(c_K_CW)) u_ky (
    .clk(clk), .rst(rst), .clr_i(w_cnt_clr), .en_i(w_hs & w_kx_wrap),
    .cnt_o(w_ky), .wrap_o(w_ky_wrap)
  );
  wrap_counter #(.MODULUS(c_OUT_W), .WIDTH(c_OX_CW)) u_ox (
    .clk(clk), .rst(rst), .clr_i(w_cnt_clr), .en_i(w_hs & w_kx_wrap & w_ky_wrap),
    .cnt_o(w_ox), .wrap_o(w_ox_wrap)
  );
  wrap_counter #(.MODULUS(c_OUT_H), .WIDTH(c_OY_CW)) u_oy (
    .clk(clk), .rst(rst), .clr_i(w_cnt_clr),
    .en_i(w_hs & w_kx_wrap & w_ky_wrap & w_ox_wrap),
    .cnt_o(w_oy), .wrap_o(w_oy_wrap)
  );

  // line/win/row hold the address of tap (0,0) of the current output row,
  // of the current window, and of the current kernel row respectively.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    win_d   = win_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_hs) begin
          if (w_final) begin
            state_d = ST_DONE;
          end else if (!w_kx_wrap) begin
            addr_d = addr_q + ADDR_W'(1);
          end else if (!w_ky_wrap) begin
            row_d  = row_q + c_ROW_STEP;
            addr_d = row_d;
          end else if (!w_ox_wrap) begin
            win_d  = win_q + c_COL_STEP;
            row_d  = win_d;
            addr_d = win_d;
          end else begin
            line_d = line_q + c_LINE_STEP;
            win_d  = line_d;
            row_d  = line_d;
            addr_d = line_d;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
    if (state_d != ST_RUN) begin
      addr_d = '0;
      row_d  = '0;
      win_d  = '0;
      line_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      row_q   <= '0;
      win_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      win_q   <= win_d;
      line_q  <= line_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = w_valid;
  assign busy       = w_valid;
  assign done       = (state_q == ST_DONE);
  assign win_first  = w_valid & (w_kx == '0) & (w_ky == '0);
  assign win_last   = w_valid & w_kx_wrap & w_ky_wrap;
  assign out_x      = 16'(w_ox);
  assign out_y      = 16'(w_oy);

endmodule
`default_nettype wire

// File: tb/tb_window_addr_gen.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_window_addr_gen: directed self-checking bench for window_addr_gen. Rev 1.0
// ------------------------------------------------------------------------
module tb_window_addr_gen;

  typedef struct packed {
    logic [18:0] a;
    logic        v;
    logic        f;
    logic        l;
    logic        b;
    logic        dn;
    logic [15:0] x;
    logic [15:0] y;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic addr_ready = 1'b0;

  logic [18:0] a0, a1, a2, a3;
  logic        v0, v1, v2, v3;
  logic        f0, f1, f2, f3;
  logic        l0, l1, l2, l3;
  logic        b0, b1, b2, b3;
  logic        dn0, dn1, dn2, dn3;
  logic [15:0] x0, x1, x2, x3;
  logic [15:0] y0, y1, y2, y3;

  int errors = 0;
  int checks = 0;
  int bases[$];
  int n_fl;

  always #5 clk = ~clk;

  // 0: 4x3 K3 S1, 1: 4x4 K3 S2, 2: 3x2 K1 S1, 3: default 512x512 K5 S1
  window_addr_gen #(.IMG_W(4), .IMG_H(3), .KERNEL(3), .STRIDE(1), .ADDR_W(19)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .addr_ready(addr_ready),
    .addr(a0), .addr_valid(v0), .win_first(f0), .win_last(l0),
    .out_x(x0), .out_y(y0), .busy(b0), .done(dn0));
  window_addr_gen #(.IMG_W(4), .IMG_H(4), .KERNEL(3), .STRIDE(2), .ADDR_W(19)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .addr_ready(addr_ready),
    .addr(a1), .addr_valid(v1), .win_first(f1), .win_last(l1),
    .out_x(x1), .out_y(y1), .busy(b1), .done(dn1));
  window_addr_gen #(.IMG_W(3), .IMG_H(2), .KERNEL(1), .STRIDE(1), .ADDR_W(19)) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .addr_ready(addr_ready),
    .addr(a2), .addr_valid(v2), .win_first(f2), .win_last(l2),
    .out_x(x2), .out_y(y2), .busy(b2), .done(dn2));
  window_addr_gen u_d (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .addr_ready(addr_ready),
    .addr(a3), .addr_valid(v3), .win_first(f3), .win_last(l3),
    .out_x(x3), .out_y(y3), .busy(b3), .done(dn3));

  function automatic obs_t obs(input int d);
    obs_t o;
    case (d)
      0:       o = '{a0, v0, f0, l0, b0, dn0, x0, y0};
      1:       o = '{a1, v1, f1, l1, b1, dn1, x1, y1};
      2:       o = '{a2, v2, f2, l2, b2, dn2, x2, y2};
      default: o = '{a3, v3, f3, l3, b3, dn3, x3, y3};
    endcase
    return o;
  endfunction

  // Reference for the 4x3 K3 S1 instance: PW=6, OUT_W=4.
  function automatic int exp_a(input int n);
    int t;
    int w;
    t = n % 9;
    w = n / 9;
    return ((w / 4) + t / 3) * 6 + (w % 4) + t % 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input int d, input int budget, output int n_hs, output int last_a,
                           output logic last_l, output int lox, output int loy,
                           output int n_done, output int gap);
    obs_t o;
    int last_cyc;
    int done_cyc;
    n_hs = 0; last_a = -1; last_l = 1'b0; lox = -1; loy = -1; n_done = 0;
    last_cyc = -1; done_cyc = -1;
    bases.delete();
    n_fl = 0;
    idle_all();
    addr_ready = 1'b1;
    start_frame();
    for (int c = 0; c < budget; c++) begin
      o = obs(d);
      if (o.v) begin
        n_hs++;
        last_a = int'(o.a); last_l = o.l; lox = int'(o.x); loy = int'(o.y);
        last_cyc = c;
        if (o.f) bases.push_back(int'(o.a));
        if (o.f && o.l) n_fl++;
      end
      if (o.dn) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc + 1) break;
      tick();
    end
    gap = (done_cyc < 0) ? -1 : done_cyc - last_cyc;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      o = obs(d);
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: outputs=%h required all zero", d, o);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_window();
    int exp_q[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    obs_t o;
    idle_all();
    addr_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 9; i++) begin
      o = obs(0);
      checks++;
      if (o.a !== 19'(exp_q[i]) || o.v !== 1'b1 || o.b !== 1'b1 ||
          o.f !== (i == 0) || o.l !== (i == 8)) begin
        errors++;
        $display("FAIL first_window tap%0d: addr=%0d v=%b busy=%b first=%b last=%b required addr=%0d v=1 busy=1 first=%b last=%b",
                 i, o.a, o.v, o.b, o.f, o.l, exp_q[i], (i == 0), (i == 8));
      end
      tick();
    end
    o = obs(0);
    checks++;
    if (o.a !== 19'd1 || o.f !== 1'b1 || o.x !== 16'd1 || o.y !== 16'd0) begin
      errors++;
      $display("FAIL second_window: addr=%0d first=%b x=%0d y=%0d required addr=1 first=1 x=1 y=0",
               o.a, o.f, o.x, o.y);
    end
  endtask

  task automatic test_full_frame();
    int n_hs, la, lox, loy, nd, gap;
    logic ll;
    obs_t o;
    run_frame(0, 200, n_hs, la, ll, lox, loy, nd, gap);
    checks++;
    if (n_hs != 108) begin
      errors++;
      $display("FAIL full_frame handshakes: got %0d required 108", n_hs);
    end
    checks++;
    if (la != 29 || ll !== 1'b1 || lox != 3 || loy != 2) begin
      errors++;
      $display("FAIL full_frame last tap: addr=%0d last=%b x=%0d y=%0d required 29 1 3 2", la, ll, lox, loy);
    end
    checks++;
    if (nd != 1 || gap != 1) begin
      errors++;
      $display("FAIL full_frame done: pulses=%0d gap=%0d required 1 1", nd, gap);
    end
    o = obs(0);
    checks++;
    if (o.v !== 1'b0 || o.b !== 1'b0 || o.dn !== 1'b0 || o.a !== 19'd0) begin
      errors++;
      $display("FAIL full_frame idle after: v=%b busy=%b done=%b addr=%0d required 0 0 0 0", o.v, o.b, o.dn, o.a);
    end
  endtask

  task automatic test_stride2();
    int exp_b[4] = '{0, 2, 12, 14};
    int n_hs, la, lox, loy, nd, gap;
    logic ll;
    run_frame(1, 100, n_hs, la, ll, lox, loy, nd, gap);
    checks++;
    if (n_hs != 36 || la != 28 || ll !== 1'b1 || lox != 1 || loy != 1) begin
      errors++;
      $display("FAIL stride2 frame: hs=%0d last=%0d wl=%b x=%0d y=%0d required 36 28 1 1 1", n_hs, la, ll, lox, loy);
    end
    checks++;
    if (bases.size() != 4) begin
      errors++;
      $display("FAIL stride2 window count: got %0d required 4", bases.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bases[i] != exp_b[i]) begin
          errors++;
          $display("FAIL stride2 base%0d: got %0d required %0d", i, bases[i], exp_b[i]);
        end
      end
    end
    checks++;
    if (nd != 1 || gap != 1) begin
      errors++;
      $display("FAIL stride2 done: pulses=%0d gap=%0d required 1 1", nd, gap);
    end
  endtask

  task automatic test_kernel1();
    int n_hs, la, lox, loy, nd, gap;
    logic ll;
    run_frame(2, 30, n_hs, la, ll, lox, loy, nd, gap);
    checks++;
    if (n_hs != 6 || la != 5 || lox != 2 || loy != 1) begin
      errors++;
      $display("FAIL kernel1 frame: hs=%0d last=%0d x=%0d y=%0d required 6 5 2 1", n_hs, la, lox, loy);
    end
    checks++;
    if (n_fl != 6) begin
      errors++;
      $display("FAIL kernel1 first_and_last taps: got %0d required 6", n_fl);
    end
    checks++;
    if (nd != 1 || gap != 1) begin
      errors++;
      $display("FAIL kernel1 done: pulses=%0d gap=%0d required 1 1", nd, gap);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    idle_all();
    addr_ready = 1'b1;
    start_frame();
    repeat (4) tick();
    addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      o = obs(0);
      checks++;
      if (o.a !== 19'd7 || o.v !== 1'b1 || o.f !== 1'b0 || o.l !== 1'b0 ||
          o.x !== 16'd0 || o.y !== 16'd0) begin
        errors++;
        $display("FAIL stall cycle%0d: addr=%0d v=%b first=%b last=%b x=%0d y=%0d required 7 1 0 0 0 0",
                 i, o.a, o.v, o.f, o.l, o.x, o.y);
      end
      tick();
    end
    addr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      o = obs(0);
      checks++;
      if (o.a !== 19'(exp_a(4 + i)) || o.v !== 1'b1) begin
        errors++;
        $display("FAIL release tap%0d: addr=%0d v=%b required %0d 1", 4 + i, o.a, o.v, exp_a(4 + i));
      end
      tick();
    end
  endtask

  task automatic test_restart_abort();
    obs_t o;
    logic seen_done;
    idle_all();
    addr_ready = 1'b1;
    start_frame();
    for (int n = 0; n < 21; n++) begin
      o = obs(0);
      checks++;
      if (o.a !== 19'(exp_a(n)) || o.v !== 1'b1) begin
        errors++;
        $display("FAIL restart_ignored tap%0d: addr=%0d v=%b required %0d 1", n, o.a, o.v, exp_a(n));
      end
      if (n == 20) break;
      start = (n == 10);
      tick();
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    o = obs(0);
    checks++;
    if (o.v !== 1'b0 || o.b !== 1'b0 || o.dn !== 1'b0 || o.a !== 19'd0 || o.x !== 16'd0) begin
      errors++;
      $display("FAIL abort: v=%b busy=%b done=%b addr=%0d x=%0d required 0 0 0 0 0", o.v, o.b, o.dn, o.a, o.x);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs(0).dn || obs(0).v) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort quiet: done_or_valid=%b required 0", seen_done);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (obs(0).v !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start: valid=%b required 0", obs(0).v);
    end
    start_frame();
    o = obs(0);
    checks++;
    if (o.a !== 19'd0 || o.f !== 1'b1 || o.v !== 1'b1) begin
      errors++;
      $display("FAIL restart: addr=%0d first=%b v=%b required 0 1 1", o.a, o.f, o.v);
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    idle_all();
    addr_ready = 1'b1;
    start_frame();
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    o = obs(0);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%h required all zero", o);
    end
    tick();
    rst = 1'b0;
    tick();
    o = obs(0);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL after_reset: outputs=%h required all zero", o);
    end
  endtask

  task automatic test_default();
    int exp_d[6] = '{0, 1, 2, 3, 4, 516};
    obs_t o;
    idle_all();
    addr_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 6; i++) begin
      o = obs(3);
      checks++;
      if (o.a !== 19'(exp_d[i]) || o.v !== 1'b1 || o.x !== 16'd0) begin
        errors++;
        $display("FAIL default tap%0d: addr=%0d v=%b x=%0d required %0d 1 0", i, o.a, o.v, o.x, exp_d[i]);
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_full_frame();
    test_stride2();
    test_kernel1();
    test_backpressure();
    test_restart_abort();
    test_async_reset();
    test_default();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
